// File: rtl/updn_mod_counter_pkg.sv
// updn_mod_counter_pkg
//   Shared constants and helpers for the up/down modulo counter.
//   DIR_UP / DIR_DN : encodings of the Up input.
//   max_count()     : highest reachable count, MODULUS-1 clamped to the
//                     range representable in WIDTH bits.
package updn_mod_counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int max_count(input int width, input int modulus);
        int lim;
        lim = 1 << width;
        return ((modulus < lim) ? modulus : lim) - 1;
    endfunction

endpackage

// File: rtl/updn_mod_counter_next.sv
// updn_mod_counter_next
//   Combinational next-state logic for updn_mod_counter.
//   Inputs : q (current count), en, up, load, d (load value)
//   Outputs: q_nxt (next count), wrap_nxt (wrap occurs on this edge),
//            tc (terminal count: the next enabled step would wrap)
//   Macro UPDN_MOD_COUNTER_SAT_EN: saturate at the terminal points instead
//   of wrapping; wrap_nxt is then never asserted.
module updn_mod_counter_next
    import updn_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_nxt,
    output logic             wrap_nxt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH, MODULUS));

    logic at_top;
    logic at_bot;

    assign at_top = (q == MAX);
    assign at_bot = (q == '0);
    assign tc     = en & ~load & (((up == DIR_UP) & at_top) | ((up == DIR_DN) & at_bot));

    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        if (load) begin
            // Out-of-range load values clamp to the top count.
            q_nxt = (d > MAX) ? MAX : d;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (at_top) begin
`ifdef UPDN_MOD_COUNTER_SAT_EN
                    q_nxt = MAX;
`else
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    q_nxt = q + WIDTH'(1);
                end
            end else begin
                // Explicit bottom check keeps q-1 from underflowing at 0.
                if (at_bot) begin
`ifdef UPDN_MOD_COUNTER_SAT_EN
                    q_nxt = '0;
`else
                    q_nxt    = MAX;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    q_nxt = q - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/updn_mod_counter.sv
// updn_mod_counter
//   Up/down modulo-MODULUS counter with synchronous load and wrap pulse.
//   CLK   : clock, all state changes on posedge
//   Reset : synchronous, active-low; clears Q and Wrap
//   En    : count enable          Up   : 1 = up, 0 = down
//   Load  : parallel load strobe  D    : load value (clamped to MODULUS-1)
//   Q     : registered count
//   TC    : combinational terminal count
//   Wrap  : registered one-cycle pulse after a wrap edge
//   Macro UPDN_MOD_COUNTER_SAT_EN: saturating variant, Wrap stays 0.
module updn_mod_counter
    import updn_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Wrap
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "updn_mod_counter: WIDTH must be 2..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "updn_mod_counter: MODULUS must be 2..2**WIDTH");
    end

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;

    updn_mod_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q        (Q),
        .en       (En),
        .up       (Up),
        .load     (Load),
        .d        (D),
        .q_nxt    (q_nxt),
        .wrap_nxt (wrap_nxt),
        .tc       (TC)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            Q    <= '0;
            Wrap <= 1'b0;
        end else begin
            Q    <= q_nxt;
            Wrap <= wrap_nxt;
        end
    end

endmodule

// File: doc/updn_mod_counter.md
UPDN_MOD_COUNTER -- requirements
Module: updn_mod_counter

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits; legal range 2..16.
REQ-002 Parameter MODULUS, default 8: count states 0..MODULUS-1; legal range 2..2**WIDTH; an illegal value SHALL stop elaboration with a fatal error.
REQ-003 CLK  input  1: single clock; all state updates on posedge.
REQ-004 Reset  input  1: reset is synchronous and active-low.
REQ-005 En  input  1: count enable.
REQ-006 Up  input  1: direction; 1 = up, 0 = down.
REQ-007 Load  input  1: synchronous parallel load strobe.
REQ-008 D  input  WIDTH: load value.
REQ-009 Q  output  WIDTH: registered count.
REQ-010 TC  output  1: combinational terminal count.
REQ-011 Wrap  output  1: registered one-cycle wrap pulse.

Function
REQ-012 Per-edge priority SHALL be Reset, then Load, then En count, then hold.
REQ-013 Load SHALL set Q to D on the next edge, independent of En and Up.
REQ-014 If D >= MODULUS on a load, Q SHALL take MODULUS-1.
REQ-015 En=1, Up=1, Q<MODULUS-1: Q SHALL become Q+1 on the next edge.
REQ-016 En=1, Up=0, Q>0: Q SHALL become Q-1 on the next edge.
REQ-017 Up-count wrap: En=1, Up=1, Q=MODULUS-1 -> Q=0 on the next edge.
REQ-018 Down-count wrap: En=1, Up=0, Q=0 -> Q=MODULUS-1 on the next edge.
REQ-019 Latency: Q SHALL change exactly one edge after a qualifying En or Load cycle.
REQ-020 TC SHALL equal En & ~Load & ((Up & Q==MODULUS-1) | (~Up & Q==0)).
REQ-021 Wrap SHALL be 1 for exactly the one cycle following an edge on which REQ-017 or REQ-018 applied; it SHALL be 0 otherwise.
REQ-022 Load on a TC cycle SHALL suppress both the wrap and Wrap.
REQ-023 Up may change on any cycle; the new direction SHALL take effect on the same edge.
REQ-024 All next-state arithmetic SHALL be WIDTH bits wide, with no unsigned underflow at Q=0.

Reset
REQ-025 Reset=0 at a posedge SHALL force Q=0 and Wrap=0, overriding Load and En.
REQ-026 Reset asserted mid-count SHALL discard any pending wrap; Wrap SHALL be 0 on the cycle after reset.
REQ-027 TC SHALL follow REQ-020 during reset; it is 0 unless En=1 and Up=0.
REQ-028 After Reset returns to 1, counting SHALL resume on the first edge with En=1.

Configuration
REQ-029 Macro UPDN_MOD_COUNTER_SAT_EN defined: at a terminal point Q SHALL hold at MODULUS-1 (up) or 0 (down); Wrap SHALL be tied to 0; TC behaviour SHALL be unchanged.
REQ-030 Macro undefined: wrap behaviour per REQ-017, REQ-018 and REQ-021.

Structure
REQ-031 Package updn_mod_counter_pkg SHALL hold the direction constants DIR_UP=1 and DIR_DN=0, and a function computing the clamped MAX value from WIDTH and MODULUS.
REQ-032 Sub-module updn_mod_counter_next SHALL compute the combinational next Q, the wrap flag and TC; the top module SHALL hold only the Q and Wrap registers.

Verification
REQ-033 WIDTH=3, MODULUS=8; Reset=0 for 1 edge, then En=1, Up=1 for 9 edges -> Q runs 1..7, 0, 1; Wrap=1 only in the cycle Q=0; TC=1 while Q=7.
REQ-034 MODULUS=6; Up=0 from Q=0 -> Q=5, 4, 3; Wrap pulses once after the 0->5 edge.
REQ-035 Load=1, D=7 with MODULUS=6 -> Q=5; Load=1, D=2 with En=1 on the same edge -> Q=2, no count.
REQ-036 Q=7 (MODULUS=8), En=1, Up=1, Reset=0 on the same edge -> Q=0, Wrap=0 on the next cycle.
REQ-037 Q=3, toggle Up on every edge with En=1 -> Q alternates 4, 3, 4, 3; En=0 -> Q holds and TC=0.
REQ-038 UPDN_MOD_COUNTER_SAT_EN defined, MODULUS=8: up from Q=6 for 3 edges -> Q=7, 7, 7; Wrap stays 0 and TC=1.
